// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one single-cycle ALU between two valid/ready requesters
module alu_share_arbiter #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [XLEN-1:0]   req_src_a0,
  input  logic [XLEN-1:0]   req_src_a1,
  input  logic [XLEN-1:0]   req_src_b0,
  input  logic [XLEN-1:0]   req_src_b1,
  input  logic [CTRL_W-1:0] req_ctrl0,
  input  logic [CTRL_W-1:0] req_ctrl1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [XLEN-1:0]   rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [XLEN-1:0]   alu_src_a,
  output logic [XLEN-1:0]   alu_src_b,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [CTRL_W-1:0] MAX_OP = CTRL_W'(6);
  state_t              state_q;
  logic                prio_q, owner_q, err_q, zero_q;
  logic [1:0]          rsp_valid_q;
  logic [XLEN-1:0]     a_q, b_q, res_q;
  logic [CTRL_W-1:0]   ctrl_q;
  logic                idle, grant0, grant1, done;
  logic [XLEN-1:0]     a_d, b_d;
  logic [CTRL_W-1:0]   ctrl_d;
  // Round-robin grant (only while idle) and operand select of the winner
  always_comb begin
    idle   = state_q == IDLE;
    grant0 = idle & req_valid[0] & (~req_valid[1] | ~prio_q);
    grant1 = idle & req_valid[1] & (~req_valid[0] | prio_q);
    done   = (state_q == RESP) & rsp_ready[owner_q];
    a_d    = grant1 ? req_src_a1 : req_src_a0;
    b_d    = grant1 ? req_src_b1 : req_src_b0;
    ctrl_d = grant1 ? req_ctrl1 : req_ctrl0;
  end
  assign req_ready   = {grant1, grant0};
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = res_q;
  assign rsp_zero    = zero_q;
  assign rsp_err     = err_q;
  assign alu_src_a   = a_q;
  assign alu_src_b   = b_q;
  assign alu_control = ctrl_q;
  // Accept -> drive ALU for one cycle -> hold response until the owner takes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      err_q       <= 1'b0;
      zero_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      ctrl_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (grant0 | grant1) begin
          a_q     <= a_d;
          b_q     <= b_d;
          ctrl_q  <= ctrl_d;
          owner_q <= grant1;
          err_q   <= ctrl_d > MAX_OP;
          prio_q  <= ~grant1;
          state_q <= EXEC;
        end
        EXEC: begin
          res_q       <= alu_result;
          zero_q      <= alu_zero;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: if (done) begin
          rsp_valid_q <= 2'b00;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench for the shared-ALU arbiter with a behavioural ALU
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_src_a0, req_src_a1, req_src_b0, req_src_b1;
  logic [3:0]  req_ctrl0, req_ctrl1, alu_control;
  logic [31:0] rsp_result, alu_src_a, alu_src_b, alu_result;
  logic        rsp_zero, rsp_err, alu_zero;
  logic [31:0] pa [2];
  logic [31:0] pb [2];
  logic [3:0]  pc [2];
  typedef struct {
    logic [1:0]  vld;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t me;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign req_src_a0 = pa[0];
  assign req_src_a1 = pa[1];
  assign req_src_b0 = pb[0];
  assign req_src_b1 = pb[1];
  assign req_ctrl0  = pc[0];
  assign req_ctrl1  = pc[1];

  alu_share_arbiter #(.XLEN(32), .CTRL_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src_a0(req_src_a0), .req_src_a1(req_src_a1),
    .req_src_b0(req_src_b0), .req_src_b1(req_src_b1),
    .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return {31'b0, $signed(a) < $signed(b)};
      4'd6:    return {31'b0, a < b};
      default: return a ^ b;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_ref(alu_src_a, alu_src_b, alu_control);
    alu_zero   = alu_result == 32'd0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] mask);
    logic [1:0] rdy;
    exp_t e;
    req_valid = mask;
    for (int i = 0; i < 60 && req_valid != 2'b00; i++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) if (rdy[k]) begin
        e.vld  = (k == 1) ? 2'b10 : 2'b01;
        e.res  = alu_ref(pa[k], pb[k], pc[k]);
        e.zero = e.res == 32'd0;
        e.err  = pc[k] > 4'd6;
        sb.push_back(e);
        req_valid[k] = 1'b0;
      end
    end
    if (req_valid != 2'b00) begin
      check("accept_timeout", req_valid, 2'b00);
      req_valid = 2'b00;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && (rsp_valid & rsp_ready) != 2'b00) begin
      if (sb.size() == 0) check("unexpected_rsp", rsp_valid, 2'b00);
      else begin
        me = sb.pop_front();
        check("rsp_valid", rsp_valid, me.vld);
        check("rsp_result", rsp_result, me.res);
        check("rsp_zero", rsp_zero, me.zero);
        check("rsp_err", rsp_err, me.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      pa[k] = '0;
      pb[k] = '0;
      pc[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_result", rsp_result, 0);
    check("rst_flags", {rsp_zero, rsp_err}, 2'b00);
    check("rst_alu", {alu_src_a, alu_src_b, alu_control}, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    // single op and latency
    pa[0] = 32'd10; pb[0] = 32'd20; pc[0] = 4'd0;
    issue(2'b01);
    @(negedge clk);
    check("lat_exec_valid", rsp_valid, 2'b00);
    check("exec_alu_a", alu_src_a, 32'd10);
    check("exec_alu_b", alu_src_b, 32'd20);
    @(negedge clk);
    check("lat_resp_valid", rsp_valid, 2'b01);
    drain();
    // reset mid-EXEC drops the op
    pa[1] = 32'd7; pb[1] = 32'd8; pc[1] = 4'd3;
    issue(2'b10);
    reset_n = 1'b0;
    #1;
    check("midrst_alu", {alu_src_a, alu_src_b, alu_control}, 0);
    check("midrst_result", rsp_result, 0);
    check("midrst_valid_ready", {rsp_valid, req_ready}, 4'b0000);
    check("midrst_flags", {rsp_zero, rsp_err}, 2'b00);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("postrst_valid", rsp_valid, 2'b00);
    end
    @(posedge clk);
    #1;
    // contention after reset: req0 first, then req1
    pa[0] = 32'd20; pb[0] = 32'd10; pc[0] = 4'd1;
    pa[1] = 32'd5;  pb[1] = 32'd5;  pc[1] = 4'd1;
    issue(2'b11);
    drain();
    // prio back to 0: req0 SLT wins over req1 SLTU
    pa[0] = 32'h0000_0000; pb[0] = 32'hF000_0001; pc[0] = 4'd5;
    pa[1] = 32'hF000_0000; pb[1] = 32'hF000_0001; pc[1] = 4'd6;
    issue(2'b11);
    drain();
    // backpressure on req1; non-owner ready ignored, no accepts while holding
    rsp_ready = 2'b01;
    pa[1] = 32'hFFFF_0000; pb[1] = 32'h0F0F_0F0F; pc[1] = 4'd2;
    pa[0] = 32'd1; pb[0] = 32'd1; pc[0] = 4'd0;
    issue(2'b10);
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("bp_exec_ready", req_ready, 2'b00);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 2'b10);
      check("bp_result", rsp_result, 32'h0F0F_0000);
      check("bp_ready", req_ready, 2'b00);
    end
    req_valid = 2'b00;
    @(posedge clk);
    #1;
    rsp_ready = 2'b11;
    drain();
    // illegal ctrl then legal op
    pa[0] = 32'h1234_5678; pb[0] = 32'h0000_00FF; pc[0] = 4'b1010;
    issue(2'b01);
    drain();
    pa[0] = 32'd1; pb[0] = 32'd2; pc[0] = 4'd0;
    issue(2'b01);
    drain();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
